// File: rtl/gemm_pkg.sv
// Shared GEMM definitions: FSM state encoding used by the core and the
// accumulate/write-back stage, plus the lane count.
package gemm_pkg;

  localparam int GEMM_LANES = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } gemm_state_t;

endpackage

// File: rtl/gemm_wb_writer.sv
// bram2 write-back engine: holds one four-lane snapshot and streams it out as
// four consecutive word writes, advancing the write address by one group each time.
module gemm_wb_writer
  import gemm_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 12
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   init,
  input  logic [AWIDTH-1:0]                      base_addr,
  input  logic                                   load,
  input  logic [GEMM_LANES-1:0][DWIDTH-1:0]      load_data,
  output logic                                   busy,
  output logic [AWIDTH-1:0]                      addr_b2,
  output logic                                   ce_b2,
  output logic                                   we_b2,
  output logic [DWIDTH-1:0]                      d_b2
);

  logic [GEMM_LANES-1:0][DWIDTH-1:0] snap;
  logic [1:0]                        lane_ptr;
  logic [AWIDTH-1:0]                 wr_addr;

  // Lane 0 is issued straight from load_data in the load cycle, so a snapshot
  // arriving while lane 3 is on the port chains into the next group with no gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap     <= '0;
      lane_ptr <= 2'd0;
      wr_addr  <= '0;
      busy     <= 1'b0;
      addr_b2  <= '0;
      ce_b2    <= 1'b0;
      we_b2    <= 1'b0;
      d_b2     <= '0;
    end else begin
      ce_b2   <= 1'b0;
      we_b2   <= 1'b0;
      addr_b2 <= '0;
      d_b2    <= '0;
      if (init) begin
        wr_addr <= base_addr;
      end
      if (load && !busy) begin
        snap     <= load_data;
        ce_b2    <= 1'b1;
        we_b2    <= 1'b1;
        addr_b2  <= wr_addr;
        d_b2     <= load_data[0];
        lane_ptr <= 2'd1;
        busy     <= 1'b1;
      end else if (busy) begin
        ce_b2    <= 1'b1;
        we_b2    <= 1'b1;
        addr_b2  <= wr_addr + AWIDTH'(lane_ptr);
        d_b2     <= snap[lane_ptr];
        lane_ptr <= lane_ptr + 2'd1;
        if (lane_ptr == 2'd3) begin
          busy    <= 1'b0;
          wr_addr <= wr_addr + AWIDTH'(GEMM_LANES);
        end
      end
    end
  end

endmodule

// File: rtl/gemm_acc_wb.sv
// GEMM accumulate/write-back stage: sums each lane over groups of beats and
// writes every group's four sums to bram2. Optional macro GEMM_ACC_RELU_EN clamps negative sums to 0.
module gemm_acc_wb
  import gemm_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 12,
  parameter int CNT_BIT = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_run,
  input  logic [CNT_BIT-1:0] i_num_cnt,
  input  logic [CNT_BIT-1:0] i_acc_len,
  input  logic [AWIDTH-1:0]  i_base_addr,
  input  logic               i_valid,
  input  logic [DWIDTH-1:0]  i_result_0,
  input  logic [DWIDTH-1:0]  i_result_1,
  input  logic [DWIDTH-1:0]  i_result_2,
  input  logic [DWIDTH-1:0]  i_result_3,
  output logic               o_idle,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [AWIDTH-1:0]  addr_b2,
  output logic               ce_b2,
  output logic               we_b2,
  output logic [DWIDTH-1:0]  d_b2,
  input  logic [DWIDTH-1:0]  q_b2,
  output logic [1:0]         dbg_state
);

  localparam logic [CNT_BIT-1:0] CNT_ONE = CNT_BIT'(1);

  // Handshake: i_valid has no ready; one beat is consumed on every cycle
  // i_valid is high while in S_ACC and is dropped silently in any other state.

  gemm_state_t                       state;
  logic [CNT_BIT-1:0]                num_cnt;
  logic [CNT_BIT-1:0]                acc_len;
  logic [CNT_BIT-1:0]                beat_cnt;
  logic [CNT_BIT-1:0]                grp_cnt;
  logic [GEMM_LANES-1:0][DWIDTH-1:0] acc;
  logic [GEMM_LANES-1:0][DWIDTH-1:0] result;
  logic [GEMM_LANES-1:0][DWIDTH-1:0] sum;
  logic [GEMM_LANES-1:0][DWIDTH-1:0] snap_val;
  logic                              start;
  logic                              beat;
  logic                              last_beat;
  logic                              grp_close;
  logic                              wr_busy;
  logic                              unused_q_b2;

  assign result      = {i_result_3, i_result_2, i_result_1, i_result_0};
  assign start       = (state == S_IDLE) && i_run;
  assign beat        = (state == S_ACC) && i_valid;
  assign last_beat   = beat && ((beat_cnt + CNT_ONE) == num_cnt);
  assign grp_close   = beat && ((grp_cnt == (acc_len - CNT_ONE)) || last_beat);
  assign unused_q_b2 = ^q_b2;

  always_comb begin
    sum      = '0;
    snap_val = '0;
    for (int k = 0; k < GEMM_LANES; k++) begin
      sum[k] = acc[k] + result[k];
`ifdef GEMM_ACC_RELU_EN
      snap_val[k] = sum[k][DWIDTH-1] ? '0 : sum[k];
`else
      snap_val[k] = sum[k];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      num_cnt  <= '0;
      acc_len  <= CNT_ONE;
      beat_cnt <= '0;
      grp_cnt  <= '0;
      acc      <= '0;
      o_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_run) begin
            num_cnt  <= i_num_cnt;
            acc_len  <= (i_acc_len == '0) ? CNT_ONE : i_acc_len;
            beat_cnt <= '0;
            grp_cnt  <= '0;
            acc      <= '0;
            o_err    <= 1'b0;
            state    <= (i_num_cnt == '0) ? S_DONE : S_ACC;
          end
        end
        S_ACC: begin
          if (i_valid) begin
            beat_cnt <= beat_cnt + CNT_ONE;
            if (grp_close) begin
              // A close while the writer still owns the previous snapshot is lost.
              acc     <= '0;
              grp_cnt <= '0;
              if (wr_busy) begin
                o_err <= 1'b1;
              end
            end else begin
              acc     <= sum;
              grp_cnt <= grp_cnt + CNT_ONE;
            end
            if (last_beat) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!wr_busy) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_idle    = (state == S_IDLE);
  assign o_busy    = (state == S_ACC) || (state == S_DRAIN);
  assign o_done    = (state == S_DONE);
  assign dbg_state = state;

  gemm_wb_writer #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_writer (
    .clk       (clk),
    .reset     (reset),
    .init      (start),
    .base_addr (i_base_addr),
    .load      (grp_close),
    .load_data (snap_val),
    .busy      (wr_busy),
    .addr_b2   (addr_b2),
    .ce_b2     (ce_b2),
    .we_b2     (we_b2),
    .d_b2      (d_b2)
  );

endmodule

// File: tb/tb_gemm_acc_wb.sv
// Self-checking bench for gemm_acc_wb: random product streams against a
// group-level reference of sums, write slots, drops and done timing.
module tb_gemm_acc_wb;
  import gemm_pkg::*;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int CW = 31;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_run;
  logic [CW-1:0] i_num_cnt;
  logic [CW-1:0] i_acc_len;
  logic [AW-1:0] i_base_addr;
  logic          i_valid;
  logic [DW-1:0] i_result_0, i_result_1, i_result_2, i_result_3;
  logic          o_idle, o_busy, o_done, o_err;
  logic [AW-1:0] addr_b2;
  logic          ce_b2, we_b2;
  logic [DW-1:0] d_b2;
  logic [DW-1:0] q_b2;
  logic [1:0]    dbg_state;

  gemm_acc_wb #(.DWIDTH(DW), .AWIDTH(AW), .CNT_BIT(CW)) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
    .i_acc_len(i_acc_len), .i_base_addr(i_base_addr), .i_valid(i_valid),
    .i_result_0(i_result_0), .i_result_1(i_result_1),
    .i_result_2(i_result_2), .i_result_3(i_result_3),
    .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .addr_b2(addr_b2), .ce_b2(ce_b2), .we_b2(we_b2), .d_b2(d_b2),
    .q_b2(q_b2), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard queues: {addr, data} and the cycle (relative to i_run) of each write
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] got_q[$];
  int               exp_cyc_q[$];
  int               got_cyc_q[$];
  int               done_q[$];
  int               t0     = 0;
  bit               mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ce_b2) begin
        got_q.push_back({addr_b2, d_b2});
        got_cyc_q.push_back(ncyc - t0);
        check("we_follows_ce", 64'(we_b2), 64'd1);
      end else begin
        check("port_quiet", 64'({we_b2, addr_b2, d_b2}), 64'd0);
      end
      if (o_done) done_q.push_back(ncyc - t0);
    end
  end

  function automatic logic [DW-1:0] model_out(input logic [DW-1:0] s);
`ifdef GEMM_ACC_RELU_EN
    return s[DW-1] ? '0 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [DW-1:0] gen_data(input int mode, input int k);
    case (mode)
      1:       return DW'(k + 1);
      2:       return DW'(1);
      3:       return (k == 0) ? 32'hFFFF_FFFB : DW'(k);
      default: return ($urandom_range(0, 1) == 1) ? DW'($urandom())
                                                  : DW'($urandom_range(0, 20)) - DW'(10);
    endcase
  endfunction

  task automatic drive_results(input logic [DW-1:0] d[4]);
    i_result_0 = d[0];
    i_result_1 = d[1];
    i_result_2 = d[2];
    i_result_3 = d[3];
  endtask

  // vmode: 0 random valid, 1 continuous, 2 every other cycle
  task automatic run_test(input string name, input int num, input int alen,
                          input logic [AW-1:0] base, input int mode, input int vmode);
    logic [DW-1:0] sums[4];
    logic [DW-1:0] d[4];
    logic [AW-1:0] waddr;
    int beats, grp_n, free, last_w, exp_done, c, len;
    bit v, exp_err;
    beats = 0; grp_n = 0; free = 0; last_w = 0; c = 0; exp_err = 1'b0;
    waddr = base;
    len = (alen == 0) ? 1 : alen;
    for (int k = 0; k < 4; k++) sums[k] = '0;
    exp_q.delete(); exp_cyc_q.delete();
    got_q.delete(); got_cyc_q.delete(); done_q.delete();

    @(negedge clk);
    t0          = ncyc;
    mon_en      = 1'b1;
    i_run       = 1'b1;
    i_num_cnt   = CW'(num);
    i_acc_len   = CW'(alen);
    i_base_addr = base;
    i_valid     = 1'b0;

    while (beats < num) begin
      @(negedge clk);
      c++;
      if (c == 1) check({name, "_busy"}, 64'(o_busy), 64'd1);
      i_run = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 4; k++) d[k] = gen_data(mode, k);
      drive_results(d);
      case (vmode)
        1:       v = 1'b1;
        2:       v = (c % 2 == 1);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      i_valid = v;
      if (v) begin
        beats++;
        grp_n++;
        for (int k = 0; k < 4; k++) sums[k] = sums[k] + d[k];
        if (grp_n == len || beats == num) begin
          // writer is free four cycles after the last accepted close
          if (c >= free) begin
            for (int k = 0; k < 4; k++) begin
              exp_q.push_back({waddr + AW'(k), model_out(sums[k])});
              exp_cyc_q.push_back(c + 1 + k);
            end
            waddr  = waddr + AW'(4);
            free   = c + 4;
            last_w = c + 4;
          end else begin
            exp_err = 1'b1;
          end
          for (int k = 0; k < 4; k++) sums[k] = '0;
          grp_n = 0;
        end
      end
    end

    exp_done = (num == 0) ? 1 : last_w + 1;
    while (c < exp_done + 3) begin
      @(negedge clk);
      c++;
      if (c == exp_done + 1) begin
        check({name, "_idle_after_done"}, 64'(o_idle), 64'd1);
        check({name, "_err"}, 64'(o_err), 64'(exp_err));
      end
      i_valid = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < 4; k++) d[k] = DW'($urandom());
      drive_results(d);
      i_run = (c < exp_done) ? ($urandom_range(0, 7) == 0) : 1'b0;
    end
    i_valid = 1'b0;
    i_run   = 1'b0;
    mon_en  = 1'b0;

    check({name, "_done_pulses"}, 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) check({name, "_done_cycle"}, 64'(done_q[0]), 64'(exp_done));
    check({name, "_write_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({name, "_wr_addr_data"}, 64'(got_q[i]), 64'(exp_q[i]));
      check({name, "_wr_cycle"}, 64'(got_cyc_q[i]), 64'(exp_cyc_q[i]));
    end
  endtask

  task automatic reset_mid_run();
    logic [DW-1:0] d[4];
    @(negedge clk);
    i_run = 1'b1; i_num_cnt = CW'(8); i_acc_len = CW'(1); i_base_addr = '0;
    i_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      i_run = 1'b0;
      for (int k = 0; k < 4; k++) d[k] = DW'($urandom());
      drive_results(d);
      i_valid = 1'b1;
    end
    check("rst_mid_err_before", 64'(o_err), 64'd1);
    check("rst_mid_writing", 64'(ce_b2), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_ce", 64'(ce_b2), 64'd0);
    check("rst_mid_idle", 64'(o_idle), 64'd1);
    check("rst_mid_err", 64'(o_err), 64'd0);
    reset   = 1'b0;
    i_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rst_mid_no_write", 64'(ce_b2), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1; i_run = 1'b0; i_num_cnt = '0; i_acc_len = '0; i_base_addr = '0;
    i_valid = 1'b0; i_result_0 = '0; i_result_1 = '0; i_result_2 = '0; i_result_3 = '0;
    q_b2 = '0;
    repeat (3) @(negedge clk);
    check("rst_idle", 64'(o_idle), 64'd1);
    check("rst_flags", 64'({o_busy, o_done, o_err, ce_b2, we_b2}), 64'd0);
    check("rst_port", 64'({addr_b2, d_b2}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_test("basic",   4, 4, 12'd0,    1, 1);
    run_test("partial", 6, 4, 12'd0,    2, 2);
    run_test("zero",    0, 3, 12'd5,    0, 1);
    run_test("ovf",     3, 1, 12'd0,    0, 1);
    run_test("ovf_clr", 4, 4, 12'd16,   0, 1);
    run_test("wrap",    1, 1, 12'd4094, 3, 1);
    run_test("len0",    5, 0, 12'd100,  0, 0);
    for (int t = 0; t < 12; t++) begin
      run_test("rand", $urandom_range(1, 20), $urandom_range(0, 6),
               AW'($urandom()), 0, $urandom_range(0, 2));
    end
    reset_mid_run();
    run_test("after_rst", 8, 4, 12'd4092, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
